// File: rtl/fft_out_reorder.sv
// fft_out_reorder: collects the scattered-address result stream of the mixed-radix
// FFT into a ping-pong RAM. Each completed frame is replayed in natural bin order
// over a valid/ready stream.
// The read path is: address issue -> synchronous RAM read -> 2-entry skid buffer.
// The skid head drives the outputs directly.
// Optional build macro FFT_OUT_DROP_CNT_EN adds an 8-bit saturating count of dropped
// frames on port drop_count.
module fft_out_reorder #(
    parameter int WIDTH = 18,
    parameter int AW    = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    input  logic                    in_en,
    input  logic [AW-1:0]           in_address,
    input  logic                    in_finish,
    output logic signed [WIDTH-1:0] out_re,
    output logic signed [WIDTH-1:0] out_im,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [AW-1:0]           out_index,
    output logic                    out_last,
    output logic                    busy,
    output logic                    overflow
`ifdef FFT_OUT_DROP_CNT_EN
    ,
    output logic [7:0]              drop_count
`endif
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE} state_t;

    // Write side
    logic            wr_bank_q;
    logic [AW:0]     wr_cnt_q;
    logic [1:0]      full_q, full_d;
    logic [1:0][AW:0] len_q;
    logic            dropping_q;
    logic            overflow_q;
    logic            wr_full, drop, wr_en, fin_wr;

    // Read side
    state_t          state_q, state_d;
    logic            rd_bank_q;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic            rd_last;
    logic            clr_full;
    logic [AW:0]     len_cur;

    // RAM output stage
    logic                 ram_vld_q;
    logic [2*WIDTH-1:0]   ram_data_q;
    logic [AW-1:0]        ram_idx_q;
    logic                 ram_last_q;

    // Skid buffer: head entry drives the ports, second entry catches in-flight data
    logic                    out_valid_q, out_valid_d;
    logic signed [WIDTH-1:0] out_re_q, out_im_q;
    logic [AW-1:0]           out_idx_q;
    logic                    out_last_q;
    logic                    sk_vld_q, sk_vld_d;
    logic [2*WIDTH-1:0]      sk_data_q;
    logic [AW-1:0]           sk_idx_q;
    logic                    sk_last_q;
    logic                    head_ld, head_sel_sk, sk_ld;
    logic                    pop, space;
    logic [1:0]              occ;

    logic busy_q, busy_d;

    logic [2*WIDTH-1:0] mem [0:1][0:DEPTH-1];

    // A frame is dropped whole once its first sample found the target bank full.
    assign wr_full = full_q[wr_bank_q];
    assign drop    = in_en & (dropping_q | wr_full);
    assign wr_en   = in_en & ~drop;
    assign fin_wr  = wr_en & in_finish;

    assign len_cur = len_q[rd_bank_q];
    assign pop     = out_valid_q & out_ready;
    // Entries held or in flight after this cycle's pop; a new read needs one free slot.
    assign occ     = {1'b0, out_valid_q} + {1'b0, sk_vld_q} + {1'b0, ram_vld_q};
    assign space   = (occ - {1'b0, pop}) < 2'd2;
    assign rd_last = ({1'b0, rd_addr} == (len_cur - 1'b1));

    // Full flags: writer sets its bank on frame finish, reader clears its bank when done.
    // The two banks always differ.
    always_comb begin
        full_d = full_q;
        if (fin_wr)
            full_d[wr_bank_q] = 1'b1;
        if (clr_full)
            full_d[rd_bank_q] = 1'b0;
    end

    // Write pointer, per-bank frame length and drop tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q  <= 1'b0;
            wr_cnt_q   <= '0;
            full_q     <= '0;
            len_q      <= '0;
            dropping_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            full_q <= full_d;
            if (fin_wr) begin
                len_q[wr_bank_q] <= wr_cnt_q + 1'b1;
                wr_cnt_q         <= '0;
                wr_bank_q        <= ~wr_bank_q;
            end else if (wr_en) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
                dropping_q <= ~in_finish;
            end
        end
    end

    // Ping-pong RAM: scattered write, synchronous natural-order read.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_bank_q][in_address] <= {in_re, in_im};
        if (rd_en) begin
            ram_data_q <= mem[rd_bank_q][rd_addr];
            ram_idx_q  <= rd_addr;
            ram_last_q <= rd_last;
        end
    end

    // Read FSM next state and address issue.
    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        rd_en    = 1'b0;
        rd_addr  = '0;
        clr_full = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    rd_en    = 1'b1;
                    rd_ptr_d = {{AW{1'b0}}, 1'b1};
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                if ((rd_ptr_q < len_cur) && space) begin
                    rd_en    = 1'b1;
                    rd_addr  = rd_ptr_q[AW-1:0];
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                if (pop && out_last_q)
                    state_d = S_DONE;
            end
            S_DONE: begin
                clr_full = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_d = (|full_d) | (state_d != S_IDLE);

    // Read FSM state, read bank, RAM output valid and busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rd_bank_q <= 1'b0;
            rd_ptr_q  <= '0;
            ram_vld_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_vld_q <= rd_en;
            busy_q    <= busy_d;
            if (clr_full)
                rd_bank_q <= ~rd_bank_q;
        end
    end

    // Skid control: the head refills from the second entry first, else from the RAM.
    always_comb begin
        out_valid_d = out_valid_q;
        sk_vld_d    = sk_vld_q;
        head_ld     = 1'b0;
        head_sel_sk = 1'b0;
        sk_ld       = 1'b0;
        if (!out_valid_q || pop) begin
            if (sk_vld_q) begin
                head_ld     = 1'b1;
                head_sel_sk = 1'b1;
                out_valid_d = 1'b1;
                sk_ld       = ram_vld_q;
                sk_vld_d    = ram_vld_q;
            end else if (ram_vld_q) begin
                head_ld     = 1'b1;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (ram_vld_q) begin
            sk_ld    = 1'b1;
            sk_vld_d = 1'b1;
        end
    end

    // Skid head: output registers, held stable while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            sk_vld_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            sk_vld_q    <= sk_vld_d;
            if (head_ld) begin
                if (head_sel_sk) begin
                    out_re_q   <= $signed(sk_data_q[2*WIDTH-1:WIDTH]);
                    out_im_q   <= $signed(sk_data_q[WIDTH-1:0]);
                    out_idx_q  <= sk_idx_q;
                    out_last_q <= sk_last_q;
                end else begin
                    out_re_q   <= $signed(ram_data_q[2*WIDTH-1:WIDTH]);
                    out_im_q   <= $signed(ram_data_q[WIDTH-1:0]);
                    out_idx_q  <= ram_idx_q;
                    out_last_q <= ram_last_q;
                end
            end
        end
    end

    // Second skid entry payload; qualified by sk_vld_q.
    always_ff @(posedge clk) begin
        if (sk_ld) begin
            sk_data_q <= ram_data_q;
            sk_idx_q  <= ram_idx_q;
            sk_last_q <= ram_last_q;
        end
    end

    assign out_valid = out_valid_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_index = out_idx_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;

`ifdef FFT_OUT_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    // Count dropped frames on their finishing sample, saturating at 255.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_cnt_q <= '0;
        else if (drop && in_finish && (drop_cnt_q != 8'hFF))
            drop_cnt_q <= drop_cnt_q + 8'd1;
    end

    assign drop_count = drop_cnt_q;
`else
    // Without the counter, overflow is the only indication of dropped frames.
`endif

endmodule

// File: tb/tb_fft_out_reorder.sv
// Scoreboard bench for fft_out_reorder: expected samples are queued when a frame is sent
// and a negedge monitor pops and compares them on every output transfer.
module tb_fft_out_reorder;

    localparam int WIDTH = 18;
    localparam int AW    = 11;

    logic                    clk = 1'b0;
    logic                    rst;
    logic signed [WIDTH-1:0] in_re, in_im;
    logic                    in_en;
    logic [AW-1:0]           in_address;
    logic                    in_finish;
    logic signed [WIDTH-1:0] out_re, out_im;
    logic                    out_valid;
    logic                    out_ready;
    logic [AW-1:0]           out_index;
    logic                    out_last;
    logic                    busy;
    logic                    overflow;
`ifdef FFT_OUT_DROP_CNT_EN
    logic [7:0]              drop_count;
`endif

    fft_out_reorder #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_re      (in_re),
        .in_im      (in_im),
        .in_en      (in_en),
        .in_address (in_address),
        .in_finish  (in_finish),
        .out_re     (out_re),
        .out_im     (out_im),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_index  (out_index),
        .out_last   (out_last),
        .busy       (busy),
        .overflow   (overflow)
`ifdef FFT_OUT_DROP_CNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [WIDTH-1:0] re;
        logic signed [WIDTH-1:0] im;
        logic [AW-1:0]           idx;
        logic                    last;
    } exp_t;

    exp_t exp_q[$];

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int last_xfer = 0;
    int xfers     = 0;
    int rdy_mode  = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // out_ready pattern: 0 = stalled, 1 = always ready, 2 = 1,0,0,1 repeating
    initial begin
        int ph;
        ph = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b0;
                1: out_ready = 1'b1;
                default: begin
                    out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
                    ph++;
                end
            endcase
        end
    end

    // Monitor: compares each transfer to the scoreboard and checks stall stability.
    initial begin
        logic                    held;
        logic signed [WIDTH-1:0] h_re, h_im;
        logic [AW-1:0]           h_idx;
        logic                    h_last;
        exp_t                    e;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("stall_valid", longint'(out_valid), 1);
                    chk("stall_re",    longint'(out_re),    longint'(h_re));
                    chk("stall_im",    longint'(out_im),    longint'(h_im));
                    chk("stall_index", longint'(out_index), longint'(h_idx));
                    chk("stall_last",  longint'(out_last),  longint'(h_last));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: index %0d re %0d, required no output",
                                 out_index, out_re);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_re",    longint'(out_re),    longint'(e.re));
                        chk("out_im",    longint'(out_im),    longint'(e.im));
                        chk("out_index", longint'(out_index), longint'(e.idx));
                        chk("out_last",  longint'(out_last),  longint'(e.last));
                    end
                    xfers++;
                    last_xfer = cyc;
                    held = 1'b0;
                end else if (out_valid) begin
                    held   = 1'b1;
                    h_re   = out_re;
                    h_im   = out_im;
                    h_idx  = out_index;
                    h_last = out_last;
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    // Send one frame; stride selects the 3x4 interleave order, otherwise address (7*i) mod n.
    // Sample at address a carries re = base + 16*a, im = -(base + a).
    task automatic send_frame(input int n, input int base, input bit stride, input bit keep);
        exp_t e;
        int   addr;
        if (keep) begin
            for (int a = 0; a < n; a++) begin
                e.re   = WIDTH'(base + a * 16);
                e.im   = WIDTH'(-(base + a));
                e.idx  = AW'(a);
                e.last = (a == n - 1);
                exp_q.push_back(e);
            end
        end
        for (int i = 0; i < n; i++) begin
            addr       = stride ? ((i % 3) * 4 + i / 3) : ((i * 7) % n);
            in_en      = 1'b1;
            in_address = AW'(addr);
            in_re      = WIDTH'(base + addr * 16);
            in_im      = WIDTH'(-(base + addr));
            in_finish  = (i == n - 1);
            @(posedge clk);
            #1;
        end
        in_en     = 1'b0;
        in_finish = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk);
            #2;
            k++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d samples outstanding, required 0", name, exp_q.size());
        end
    endtask

    initial begin
        int  x0;
        bit  found;
        rst        = 1'b1;
        in_en      = 1'b0;
        in_finish  = 1'b0;
        in_address = '0;
        in_re      = '0;
        in_im      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid",    longint'(out_valid), 0);
        chk("rst_last",     longint'(out_last),  0);
        chk("rst_index",    longint'(out_index), 0);
        chk("rst_re",       longint'(out_re),    0);
        chk("rst_im",       longint'(out_im),    0);
        chk("rst_busy",     longint'(busy),      0);
        chk("rst_overflow", longint'(overflow),  0);
`ifdef FFT_OUT_DROP_CNT_EN
        chk("rst_drop_count", longint'(drop_count), 0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        // N=12 interleaved, data = 16*address; first valid 3 cycles after the finish sample
        send_frame(12, 0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("lat_t2_valid", longint'(out_valid), 0);
        @(posedge clk);
        #1;
        chk("lat_t3_valid", longint'(out_valid), 1);
        chk("lat_t3_index", longint'(out_index), 0);
        wait_drain(100, "single12");

        // Two N=60 frames back to back, then busy must fall two cycles after the last transfer
        repeat (3) @(posedge clk);
        #1;
        send_frame(60, 1000, 1'b0, 1'b1);
        send_frame(60, 2000, 1'b0, 1'b1);
        wait_drain(400, "b2b60");
        if (cyc == last_xfer + 1)
            chk("busy_after1", longint'(busy), 1);
        while (cyc < last_xfer + 2) begin
            @(posedge clk);
            #2;
        end
        chk("busy_after2", longint'(busy), 0);
        chk("b2b_overflow", longint'(overflow), 0);

        // N=36 with out_ready 1,0,0,1 repeating
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        send_frame(36, 3000, 1'b0, 1'b1);
        wait_drain(400, "backpressure36");
        rdy_mode = 1;

        // Overflow: three N=12 frames while stalled, third one dropped
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        x0 = xfers;
        send_frame(12, 4000, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        send_frame(12, 5000, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("ovf_before_drop", longint'(overflow), 0);
        send_frame(12, 6000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("ovf_after_drop", longint'(overflow), 1);
`ifdef FFT_OUT_DROP_CNT_EN
        chk("ovf_drop_count", longint'(drop_count), 1);
`endif
        chk("ovf_no_xfer_stalled", longint'(xfers - x0), 0);
        rdy_mode = 1;
        wait_drain(200, "overflow");
        repeat (10) @(posedge clk);
        #1;
        chk("ovf_xfer_count", longint'(xfers - x0), 24);
        chk("ovf_sticky", longint'(overflow), 1);

        // Reset while index 5 of an N=24 frame is presented
        send_frame(24, 7000, 1'b0, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(posedge clk);
            #2;
            if (out_valid && out_index == 5)
                found = 1'b1;
        end
        chk("rstmid_reach_idx5", longint'(found), 1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("rstmid_valid",    longint'(out_valid), 0);
        chk("rstmid_last",     longint'(out_last),  0);
        chk("rstmid_index",    longint'(out_index), 0);
        chk("rstmid_re",       longint'(out_re),    0);
        chk("rstmid_im",       longint'(out_im),    0);
        chk("rstmid_busy",     longint'(busy),      0);
        chk("rstmid_overflow", longint'(overflow),  0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_frame(12, 8000, 1'b1, 1'b1);
        wait_drain(100, "after_reset12");

        // N=1: single sample is both index 0 and last
        repeat (2) @(posedge clk);
        #1;
        send_frame(1, 9000, 1'b0, 1'b1);
        wait_drain(50, "single1");
        repeat (5) @(posedge clk);
        #1;
        chk("final_busy", longint'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
